// File: rtl/bus_arb.sv
// bus_arb: arbitrates the fetch (I) and data (D) requesters onto the shared
// 16-bit external bus. Each 64-bit request is serialised into BEATS 16-bit
// beats. Read beats are reassembled little-endian and returned with a
// one-cycle acknowledge.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   - per-beat wait counter; a beat that waits TIMEOUT-1 cycles
//               aborts the transaction, acks with err=1, read data all ones
//   undefined - no counter, err is always 0, a missing dbv stalls forever
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   i_addr/i_req         fetch request (read only)
//   i_data/i_ack         fetch read data and one-cycle completion pulse
//   d_addr/d_wdata/d_we  data request address, write payload, write enable
//   d_req                data request
//   d_data/d_ack         data read data and one-cycle completion pulse
//   err                  bus error, qualifies i_ack/d_ack
//   addr/data_out/r/w    external bus address, write beat, read/write strobes
//   data_in/dbv          external read beat and beat-done
module bus_arb #(
  parameter int PHY_ADDR = 48,
  parameter int BEATS    = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PHY_ADDR-1:0]   i_addr,
  input  logic                  i_req,
  output logic [16*BEATS-1:0]   i_data,
  output logic                  i_ack,
  input  logic [PHY_ADDR-1:0]   d_addr,
  input  logic [16*BEATS-1:0]   d_wdata,
  input  logic                  d_we,
  input  logic                  d_req,
  output logic [16*BEATS-1:0]   d_data,
  output logic                  d_ack,
  output logic                  err,
  output logic [PHY_ADDR-1:0]   addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  r,
  output logic                  w,
  input  logic                  dbv
);

  localparam int DW = 16 * BEATS;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [DW-1:0] ALL_ONES  = {DW{1'b1}};
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  logic [BW-1:0]       beat_r;
  logic                rr_last_r;
  logic                owner_r;
  logic [PHY_ADDR-1:0] base_r;
  logic [DW-1:0]       wdata_r;
  logic [DW-1:0]       buf_r;

  logic                gnt_valid_s;
  logic                gnt_owner_s;
  logic [BW-1:0]       nxt_beat_s;
  logic                last_beat_s;
  logic [DW-1:0]       rd_word_s;
  logic                tmo_s;

  // Insert one 16-bit beat into a word; beat 0 occupies bits 15:0.
  function automatic logic [DW-1:0] put_beat(input logic [DW-1:0] word,
                                             input logic [BW-1:0] idx,
                                             input logic [15:0]   beat);
    logic [DW-1:0] res;
    res = word;
    res[16*idx +: 16] = beat;
    return res;
  endfunction

  // Extract one 16-bit beat from a word; beat 0 is bits 15:0.
  function automatic logic [15:0] get_beat(input logic [DW-1:0] word,
                                           input logic [BW-1:0] idx);
    return word[16*idx +: 16];
  endfunction

  // Byte address of a beat: base plus two bytes per beat, wrapping silently.
  function automatic logic [PHY_ADDR-1:0] beat_addr(input logic [PHY_ADDR-1:0] base,
                                                    input logic [BW-1:0]       idx);
    return base + (PHY_ADDR'(idx) << 1);
  endfunction

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_r;

  assign tmo_s = (tcnt_r == TW'(TIMEOUT - 1)) && !dbv;

  // Per-beat wait counter: runs only while a beat is outstanding, clears on dbv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_r <= {TW{1'b0}};
    end else if ((state_r == RD) || (state_r == WR)) begin
      if (dbv) begin
        tcnt_r <= {TW{1'b0}};
      end else begin
        tcnt_r <= tcnt_r + TW'(1);
      end
    end else begin
      tcnt_r <= {TW{1'b0}};
    end
  end
`else
  logic unused_s;

  assign tmo_s    = 1'b0;
  assign unused_s = (TIMEOUT == 0);
`endif

  // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_owner_s = OWN_I;
    if (i_req && d_req) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = ~rr_last_r;
    end else if (i_req) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = OWN_I;
    end else if (d_req) begin
      gnt_valid_s = 1'b1;
      gnt_owner_s = OWN_D;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_owner_s = OWN_I;
    end
  end

  // Beat bookkeeping and the read word including the beat currently on data_in.
  always_comb begin
    nxt_beat_s  = beat_r + BW'(1);
    last_beat_s = (beat_r == LAST_BEAT);
    rd_word_s   = put_beat(buf_r, beat_r, data_in);
  end

  // Transaction FSM; every bus-side and requester-side output is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      beat_r    <= {BW{1'b0}};
      rr_last_r <= OWN_I;
      owner_r   <= OWN_I;
      base_r    <= {PHY_ADDR{1'b0}};
      wdata_r   <= {DW{1'b0}};
      buf_r     <= {DW{1'b0}};
      addr      <= {PHY_ADDR{1'b0}};
      data_out  <= 16'h0000;
      r         <= 1'b0;
      w         <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      i_data    <= {DW{1'b0}};
      d_data    <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          err   <= 1'b0;
          if (gnt_valid_s) begin
            owner_r   <= gnt_owner_s;
            rr_last_r <= gnt_owner_s;
            beat_r    <= {BW{1'b0}};
            wdata_r   <= d_wdata;
            if (gnt_owner_s == OWN_D) begin
              base_r <= d_addr;
              addr   <= d_addr;
            end else begin
              base_r <= i_addr;
              addr   <= i_addr;
            end
            if ((gnt_owner_s == OWN_D) && d_we) begin
              state_r  <= WR;
              w        <= 1'b1;
              r        <= 1'b0;
              data_out <= get_beat(d_wdata, {BW{1'b0}});
            end else begin
              state_r <= RD;
              r       <= 1'b1;
              w       <= 1'b0;
            end
          end else begin
            r <= 1'b0;
            w <= 1'b0;
          end
        end

        RD, WR: begin
          if (tmo_s || (dbv && last_beat_s)) begin
            // Last beat taken (or beat abandoned): drop strobes and ack the owner.
            state_r <= DONE;
            r       <= 1'b0;
            w       <= 1'b0;
            beat_r  <= {BW{1'b0}};
            err     <= tmo_s;
            if (owner_r == OWN_I) begin
              i_ack <= 1'b1;
            end else begin
              d_ack <= 1'b1;
            end
            if (state_r == RD) begin
              buf_r <= tmo_s ? ALL_ONES : rd_word_s;
              if (owner_r == OWN_I) begin
                i_data <= tmo_s ? ALL_ONES : rd_word_s;
              end else begin
                d_data <= tmo_s ? ALL_ONES : rd_word_s;
              end
            end
          end else if (dbv) begin
            beat_r <= nxt_beat_s;
            addr   <= beat_addr(base_r, nxt_beat_s);
            if (state_r == RD) begin
              buf_r <= rd_word_s;
            end else begin
              data_out <= get_beat(wdata_r, nxt_beat_s);
            end
          end
        end

        DONE: begin
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          err     <= 1'b0;
          r       <= 1'b0;
          w       <= 1'b0;
          beat_r  <= {BW{1'b0}};
          state_r <= IDLE;
        end

        default: begin
          state_r <= IDLE;
          r       <= 1'b0;
          w       <= 1'b0;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
          err     <= 1'b0;
          beat_r  <= {BW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: the driver pushes expected transactions in
// round-robin order computed from the arbitration rule; a negedge monitor acts
// as the bus slave and checks every strobe cycle and every acknowledge.
module tb_bus_arb;
  localparam int PA = 48;
  localparam int NB = 4;
  localparam int DW = 16 * NB;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PA-1:0] i_addr = '0;
  logic          i_req = 1'b0;
  logic [DW-1:0] i_data;
  logic          i_ack;
  logic [PA-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_we = 1'b0;
  logic          d_req = 1'b0;
  logic [DW-1:0] d_data;
  logic          d_ack;
  logic          err;
  logic [PA-1:0] addr;
  logic [15:0]   data_in = 16'h0000;
  logic [15:0]   data_out;
  logic          r;
  logic          w;
  logic          dbv = 1'b0;

  bus_arb #(.PHY_ADDR(PA), .BEATS(NB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req(i_req), .i_data(i_data), .i_ack(i_ack),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_req(d_req),
    .d_data(d_data), .d_ack(d_ack), .err(err),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .r(r), .w(w), .dbv(dbv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          own;   // 0 = fetch, 1 = data
    logic          we;
    logic [PA-1:0] base;
    logic [DW-1:0] wdata;
    logic          tmo;
  } txn_t;

  txn_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            beat_cnt = 0;
  logic [DW-1:0] rd_word = '0;
  logic [DW-1:0] mdl_i_data = '0;
  logic [DW-1:0] mdl_d_data = '0;
  logic          mdl_rr = 1'b0;
  int            slave_mode = 0;  // 0 dbv always, 1 random, 2 alternate, 3 never
  int            miss_cnt = 0;
  logic          alt = 1'b0;
  logic          use_fixed = 1'b0;
  logic          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic own);
    txn_t t;
    t.own   = own;
    t.we    = own ? d_we : 1'b0;
    t.base  = own ? d_addr : i_addr;
    t.wdata = d_wdata;
    t.tmo   = (slave_mode == 3);
    exp_q.push_back(t);
  endtask

  // Issue n_i fetch and n_d data requests (held until their last ack).
  task automatic run(input int n_i, input int n_d, input logic drop_early, output int lat);
    int   pi, pd, ci, cd, cyc;
    logic own;
    pi = n_i;
    pd = n_d;
    while (pi > 0 || pd > 0) begin
      if (pi > 0 && pd > 0) own = ~mdl_rr;
      else if (pi > 0)      own = 1'b0;
      else                  own = 1'b1;
      push(own);
      mdl_rr = own;
      if (own) pd--; else pi--;
    end
    ci = 0; cd = 0; cyc = 0; lat = -1;
    i_req = (n_i > 0);
    d_req = (n_d > 0);
    while ((ci < n_i || cd < n_d) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if ((i_ack || d_ack) && lat < 0) lat = cyc;
      if (i_ack) begin ci++; if (ci >= n_i) i_req = 1'b0; end
      if (d_ack) begin cd++; if (cd >= n_d) d_req = 1'b0; end
      if (drop_early && (r || w)) begin i_req = 1'b0; d_req = 1'b0; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("ack_count", 64'(ci + cd), 64'(n_i + n_d));
  endtask

  // Bus slave and scoreboard monitor, working mid-cycle.
  always @(negedge clk) begin : mon
    txn_t          t;
    logic [PA-1:0] ea;
    logic          dv;
    logic [15:0]   din;
    if (rst || !mon_en) begin
      dbv = 1'b0;
    end else begin
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", {62'b0, i_ack, d_ack}, 64'd0);
        end else begin
          t = exp_q.pop_front();
          chk("ack_owner", {62'b0, i_ack, d_ack}, t.own ? 64'd1 : 64'd2);
          chk("ack_strobes_idle", {62'b0, r, w}, 64'd0);
          chk("ack_err", {63'b0, err}, {63'b0, t.tmo});
          if (!t.tmo) chk("ack_beats", 64'(beat_cnt), 64'(NB));
          if (!t.we) begin
            if (t.own) mdl_d_data = t.tmo ? {DW{1'b1}} : rd_word;
            else       mdl_i_data = t.tmo ? {DW{1'b1}} : rd_word;
          end
          chk("ack_i_data", i_data, mdl_i_data);
          chk("ack_d_data", d_data, mdl_d_data);
          beat_cnt = 0;
          rd_word  = '0;
          alt      = 1'b0;
          miss_cnt = 0;
        end
      end
      if (r || w) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", {62'b0, r, w}, 64'd0);
        end else begin
          t  = exp_q[0];
          ea = t.base + PA'(2 * beat_cnt);
          chk("beat_r", {63'b0, r}, {63'b0, ~t.we});
          chk("beat_w", {63'b0, w}, {63'b0, t.we});
          chk("beat_addr", {16'b0, addr}, {16'b0, ea});
          if (t.we && beat_cnt < NB) chk("beat_data_out", {48'b0, data_out}, {48'b0, t.wdata[16*beat_cnt +: 16]});
        end
        case (slave_mode)
          0: dv = 1'b1;
          1: dv = (miss_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          2: begin alt = ~alt; dv = alt; end
          default: dv = 1'b0;
        endcase
        miss_cnt = dv ? 0 : miss_cnt + 1;
      end else begin
        // stray dbv while no beat is outstanding must be ignored
        dv = (slave_mode < 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      din = use_fixed ? 16'(16'h1111 * (beat_cnt + 1)) : 16'($urandom());
      if (dv && (r || w) && exp_q.size() > 0 && beat_cnt < NB) begin
        if (r) rd_word[16*beat_cnt +: 16] = din;
        beat_cnt++;
      end
      dbv     = dv;
      data_in = din;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_r", {63'b0, r}, 64'd0);
    chk("rst_w", {63'b0, w}, 64'd0);
    chk("rst_i_ack", {63'b0, i_ack}, 64'd0);
    chk("rst_d_ack", {63'b0, d_ack}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_addr", {16'b0, addr}, 64'd0);
    chk("rst_data_out", {48'b0, data_out}, 64'd0);
    chk("rst_i_data", i_data, 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // tie from reset: expected order D, I, D, I
    i_addr = 48'h0000_0000_0100; d_addr = 48'h0000_0000_0200;
    d_we = 1'b0; slave_mode = 1;
    run(2, 2, 1'b0, lat);
    repeat (2) @(negedge clk);

    // fetch read, zero-wait, fixed beat pattern
    slave_mode = 0; use_fixed = 1'b1;
    i_addr = 48'h0000_0000_1000;
    run(1, 0, 1'b0, lat);
    chk("fetch_latency", 64'(lat), 64'(NB + 1));
    chk("fetch_data", i_data, 64'h4444_3333_2222_1111);
    use_fixed = 1'b0;
    repeat (2) @(negedge clk);

    // data write, dbv every second cycle
    slave_mode = 2; d_we = 1'b1;
    d_addr = 48'h0000_0000_2000; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    run(0, 1, 1'b0, lat);
    repeat (2) @(negedge clk);

    // address wrap on a data read
    slave_mode = 0; d_we = 1'b0;
    d_addr = 48'hFFFF_FFFF_FFFE;
    run(0, 1, 1'b0, lat);
    chk("wrap_latency", 64'(lat), 64'(NB + 1));
    repeat (2) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      int   m;
      logic de;
      m = $urandom_range(0, 2);
      slave_mode = $urandom_range(0, 2);
      i_addr  = PA'({$urandom(), $urandom()});
      d_addr  = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFC : PA'({$urandom(), $urandom()});
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = {$urandom(), $urandom()};
      de = (m != 2) && ($urandom_range(0, 2) == 0);
      run((m == 1) ? 0 : 1, (m == 0) ? 0 : 1, de, lat);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // reset in the middle of a read: strobe drops at once, no ack
    slave_mode = 0;
    i_addr = 48'h0000_0000_3000;
    push(1'b0);
    i_req = 1'b1;
    cyc = 0;
    while (beat_cnt < 2 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("rst_mid_reached", {63'b0, (beat_cnt >= 2)}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_r_drop", {63'b0, r}, 64'd0);
    chk("rst_mid_no_ack", {62'b0, i_ack, d_ack}, 64'd0);
    i_req = 1'b0;
    exp_q.delete();
    beat_cnt = 0; rd_word = '0; mdl_i_data = '0; mdl_d_data = '0; mdl_rr = 1'b0;
    miss_cnt = 0; alt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_ack_held", {62'b0, i_ack, d_ack}, 64'd0);
    chk("rst_mid_i_data", i_data, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    i_addr = 48'h0000_0000_4000;
    run(1, 0, 1'b0, lat);
    chk("after_rst_latency", 64'(lat), 64'(NB + 1));
    repeat (2) @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      slave_mode = $urandom_range(0, 2);
      i_addr  = PA'({$urandom(), $urandom()});
      d_addr  = PA'({$urandom(), $urandom()});
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = {$urandom(), $urandom()};
      run(1, 1, 1'b0, lat);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

`ifdef BUS_TIMEOUT_EN
    // no dbv at all: abort with err and all-ones data
    slave_mode = 3;
    i_addr = 48'h0000_0000_5000;
    run(1, 0, 1'b0, lat);
    chk("timeout_data", i_data, {DW{1'b1}});
    slave_mode = 0;
    repeat (2) @(negedge clk);
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
